// File: rtl/i2c_target_regs.sv
// i2c_target_regs: oversampled I2C target with a pointer-addressed byte register file.
module i2c_target_regs #(
  parameter logic [6:0] ADDR = 7'h50,
  parameter int DEPTH = 16,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          rx_valid,
  output logic [PW-1:0] rx_idx,
  output logic [7:0]    rx_data,
  input  logic [PW-1:0] reg_addr,
  output logic [7:0]    reg_rdata,
  output logic          busy
);
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
  } state_t;
  state_t state, state_d;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt;
  logic [7:0] sr, tx;
  logic [PW-1:0] ptr;
  logic [7:0] regs [DEPTH];
  logic start, stop, rise, fall, sda, byte_done, match;
  logic shift_in, load_rd, commit, rd_done, sda_oe_d, busy_d;
  // [1] is the synchronized level, [2] the history flop used for edge detect
  assign start = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign rise = scl_q[1] & ~scl_q[2];
  assign fall = ~scl_q[1] & scl_q[2];
  assign sda = sda_q[1];
  assign byte_done = fall && cnt == 4'd8;
  assign match = sr[7:1] == ADDR;
  assign shift_in = rise && (state == S_ADDR || state == S_PTR || state == S_WDATA);
  assign load_rd = fall && ((state == S_ADDR_ACK && sr[0]) || state == S_RDATA_ACK);
  assign commit = byte_done && state == S_WDATA;
  assign rd_done = byte_done && state == S_RDATA;
  assign reg_rdata = regs[reg_addr];

  always_ff @(posedge clk)
    if (!resetn) state <= S_IDLE;
    else state <= state_d;

  always_comb begin
    state_d = state;
    if (start) state_d = S_ADDR;
    else if (stop) state_d = S_IDLE;
    else
      case (state)
        S_ADDR:                 if (byte_done) state_d = match ? S_ADDR_ACK : S_WAIT;
        S_ADDR_ACK:             if (fall) state_d = sr[0] ? S_RDATA : S_PTR;
        S_PTR:                  if (byte_done) state_d = S_PTR_ACK;
        S_PTR_ACK, S_WDATA_ACK: if (fall) state_d = S_WDATA;
        S_WDATA:                if (byte_done) state_d = S_WDATA_ACK;
        S_RDATA:                if (byte_done) state_d = S_RDATA_ACK;
        S_RDATA_ACK:            state_d = (rise && sda) ? S_WAIT : fall ? S_RDATA : state;
        default: ;
      endcase
  end

  // SDA only moves on SCL fall; bus conditions always release it
  always_comb begin
    sda_oe_d = sda_oe;
    busy_d = busy;
    if (start || stop) begin
      sda_oe_d = 1'b0;
      busy_d = busy & start;
    end else if (fall)
      case (state)
        S_ADDR: if (byte_done) begin
          sda_oe_d = match;
          busy_d = match;
        end
        S_PTR, S_WDATA:          if (byte_done) sda_oe_d = 1'b1;
        S_RDATA:                 sda_oe_d = !byte_done && !tx[7];
        S_ADDR_ACK, S_RDATA_ACK: sda_oe_d = load_rd && !regs[ptr][7];
        default:                 sda_oe_d = 1'b0;
      endcase
  end

  always_ff @(posedge clk)
    if (!resetn) begin
      scl_q <= '0;
      sda_q <= '0;
      cnt <= '0;
      sr <= '0;
      tx <= '0;
      ptr <= '0;
      regs <= '{default: '0};
      sda_oe <= 1'b0;
      busy <= 1'b0;
      rx_valid <= 1'b0;
      rx_idx <= '0;
      rx_data <= '0;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
      sda_oe <= sda_oe_d;
      busy <= busy_d;
      rx_valid <= commit;
      if (start || (fall && state_d != state)) cnt <= load_rd ? 4'd1 : 4'd0;
      else if (shift_in || (fall && state == S_RDATA)) cnt <= cnt + 4'd1;
      if (shift_in) sr <= {sr[6:0], sda};
      if (load_rd) tx <= {regs[ptr][6:0], 1'b1};
      else if (fall && state == S_RDATA) tx <= {tx[6:0], 1'b1};
      if (byte_done && state == S_PTR) ptr <= sr[PW-1:0];
      else if (commit || rd_done) ptr <= ptr + PW'(1);
      if (commit) begin
        regs[ptr] <= sr;
        rx_idx <= ptr;
        rx_data <= sr;
      end
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C master against a register-file model of the target.
module tb_i2c_target_regs;
  localparam int Q = 60;
  logic clk = 1'b0, resetn = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oe, rx_valid, busy, sda_line, prev_rx = 1'b0, rd_ack;
  logic [3:0] rx_idx, reg_addr = '0;
  logic [7:0] rx_data, reg_rdata;
  logic [7:0] mregs [16];
  logic [7:0] tx_buf [16];
  logic [7:0] rd_buf [16];
  logic ack_buf [16];
  logic [11:0] got_q[$], exp_q[$];
  int mptr = 0, n_cmp = 0, n_fail = 0;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_target_regs #(.ADDR(7'h50), .DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(sda_oe), .rx_valid(rx_valid), .rx_idx(rx_idx), .rx_data(rx_data),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata), .busy(busy)
  );

  always @(negedge clk) begin
    if (resetn && rx_valid) begin
      got_q.push_back({rx_idx, rx_data});
      n_cmp++;
      if (sda_oe !== 1'b1) begin
        n_fail++;
        $display("FAIL rx_ack_align: sda_oe=%b with rx_valid, want 1", sda_oe);
      end
      n_cmp++;
      if (prev_rx !== 1'b0) begin
        n_fail++;
        $display("FAIL rx_pulse_width: rx_valid high in consecutive cycles, want single-cycle pulse");
      end
    end
    prev_rx = rx_valid;
  end

  task automatic send_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_line; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic start_c;
    if (!scl_m) begin
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
    end
    sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic stop_c;
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(x);
      b[i] = x;
    end
    send_bit(nack);
  endtask

  // Master write of address a, pointer p, then n bytes of tx_buf; the model follows when addressed.
  task automatic write_txn(input logic [7:0] a, input logic [7:0] p, input int n);
    logic k;
    logic hit;
    hit = a == 8'hA0;
    start_c;
    send_byte(a, k); ack_buf[0] = k;
    send_byte(p, k); ack_buf[1] = k;
    if (hit) mptr = int'(p) % 16;
    for (int i = 0; i < n; i++) begin
      send_byte(tx_buf[i], k);
      ack_buf[i+2] = k;
      if (hit) begin
        exp_q.push_back({4'(mptr), tx_buf[i]});
        mregs[mptr] = tx_buf[i];
        mptr = (mptr + 1) % 16;
      end
    end
  endtask

  task automatic read_txn(input int n);
    logic k;
    logic [7:0] b;
    start_c;
    send_byte(8'hA1, k);
    rd_ack = k;
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      rd_buf[i] = b;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({sda_oe, rx_valid, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl: sda_oe/rx_valid/busy=%b want 000", {sda_oe, rx_valid, busy});
    end
    n_cmp++;
    if ({rx_idx, rx_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_rx: idx/data=%h want 000", {rx_idx, rx_data});
    end
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;
    for (int i = 0; i < 16; i++) begin
      reg_addr = 4'(i); #1;
      n_cmp++;
      if (reg_rdata !== mregs[i]) begin
        n_fail++;
        $display("FAIL reset_reg[%0d]: got %h want %h", i, reg_rdata, mregs[i]);
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write_basic;
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22;
    write_txn(8'hA0, 8'h03, 2);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ack_buf[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_ack[%0d]: got %b want 0", i, ack_buf[i]);
      end
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    stop_c;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_stop: got %b want 0", busy);
    end
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== 12'h311 || got_q[1] !== 12'h422) begin
      n_fail++;
      $display("FAIL basic_rx: got %0d pulses %p want (3,11),(4,22)", got_q.size(), got_q);
    end
    got_q.delete(); exp_q.delete();
    reg_addr = 4'd4; #1;
    n_cmp++;
    if (reg_rdata !== 8'h22) begin
      n_fail++;
      $display("FAIL basic_reg4: got %h want 22", reg_rdata);
    end
  endtask

  task automatic test_wrap;
    tx_buf[0] = 8'hAA; tx_buf[1] = 8'hBB;
    write_txn(8'hA0, 8'h0F, 2);
    stop_c;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ack_buf[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_ack[%0d]: got %b want 0", i, ack_buf[i]);
      end
    end
    reg_addr = 4'd15; #1;
    n_cmp++;
    if (reg_rdata !== 8'hAA) begin
      n_fail++;
      $display("FAIL wrap_reg15: got %h want aa", reg_rdata);
    end
    reg_addr = 4'd0; #1;
    n_cmp++;
    if (reg_rdata !== 8'hBB) begin
      n_fail++;
      $display("FAIL wrap_reg0: got %h want bb", reg_rdata);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap_rx_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else
      foreach (exp_q[i]) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL wrap_rx[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    got_q.delete(); exp_q.delete();
    // a pointer-less read starts where the wrapped write left off
    read_txn(1);
    stop_c;
    n_cmp++;
    if (rd_ack !== 1'b0 || rd_buf[0] !== mregs[1]) begin
      n_fail++;
      $display("FAIL wrap_ptr_read: ack=%b data=%h want ack 0 data %h", rd_ack, rd_buf[0], mregs[1]);
    end
    mptr = 2;
  endtask

  task automatic test_read;
    write_txn(8'hA0, 8'h02, 0);
    read_txn(3);
    n_cmp++;
    if (ack_buf[0] !== 1'b0 || ack_buf[1] !== 1'b0 || rd_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL read_acks: addr=%b ptr=%b raddr=%b want 000", ack_buf[0], ack_buf[1], rd_ack);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd_buf[i] !== mregs[(mptr + i) % 16]) begin
        n_fail++;
        $display("FAIL read_data[%0d]: got %h want %h", i, rd_buf[i], mregs[(mptr + i) % 16]);
      end
    end
    mptr = (mptr + 3) % 16;
    n_cmp++;
    if (sda_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL read_release: sda_oe=%b after NACK want 0", sda_oe);
    end
    stop_c;
    read_txn(1);
    stop_c;
    n_cmp++;
    if (rd_buf[0] !== mregs[mptr]) begin
      n_fail++;
      $display("FAIL read_ptr_after: got %h want %h", rd_buf[0], mregs[mptr]);
    end
    mptr = (mptr + 1) % 16;
  endtask

  task automatic test_mismatch;
    tx_buf[0] = 8'h77;
    write_txn(8'hA2, 8'h05, 1);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_busy: got %b want 0", busy);
    end
    stop_c;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ack_buf[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL mis_nack[%0d]: got %b want 1", i, ack_buf[i]);
      end
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL mis_rx: got %0d pulses want 0", got_q.size());
    end
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      reg_addr = 4'(i); #1;
      n_cmp++;
      if (reg_rdata !== mregs[i]) begin
        n_fail++;
        $display("FAIL mis_reg[%0d]: got %h want %h", i, reg_rdata, mregs[i]);
      end
    end
    start_c;
    send_byte(8'hA0, ack_buf[0]);
    n_cmp++;
    if (ack_buf[0] !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_rearm: ack=%b busy=%b want 0/1", ack_buf[0], busy);
    end
    stop_c;
  endtask

  task automatic test_random;
    logic [7:0] p;
    int n;
    for (int t = 0; t < 5; t++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
      write_txn(8'hA0, p, n);
      stop_c;
      for (int i = 0; i < n + 2; i++) begin
        n_cmp++;
        if (ack_buf[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_ack[%0d.%0d]: got %b want 0", t, i, ack_buf[i]);
        end
      end
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rnd_rx_count[%0d]: got %0d want %0d", t, got_q.size(), exp_q.size());
      end else
        foreach (exp_q[i]) begin
          n_cmp++;
          if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rnd_rx[%0d.%0d]: got %h want %h", t, i, got_q[i], exp_q[i]);
          end
        end
      got_q.delete(); exp_q.delete();
      n = $urandom_range(1, 6);
      write_txn(8'hA0, 8'($urandom_range(0, 255)), 0);
      read_txn(n);
      stop_c;
      for (int i = 0; i < n; i++) begin
        n_cmp++;
        if (rd_buf[i] !== mregs[(mptr + i) % 16]) begin
          n_fail++;
          $display("FAIL rnd_read[%0d.%0d]: got %h want %h", t, i, rd_buf[i], mregs[(mptr + i) % 16]);
        end
      end
      mptr = (mptr + n) % 16;
    end
    for (int i = 0; i < 16; i++) begin
      reg_addr = 4'(i); #1;
      n_cmp++;
      if (reg_rdata !== mregs[i]) begin
        n_fail++;
        $display("FAIL rnd_reg[%0d]: got %h want %h", i, reg_rdata, mregs[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    logic k;
    b = 8'hC3;
    write_txn(8'hA0, 8'h07, 0);
    for (int i = 7; i >= 4; i--) send_bit(b[i]);
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;
    n_cmp++;
    if (sda_oe !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_ctl: sda_oe=%b busy=%b want 0/0", sda_oe, busy);
    end
    for (int i = 0; i < 16; i++) begin
      reg_addr = 4'(i); #1;
      n_cmp++;
      if (reg_rdata !== mregs[i]) begin
        n_fail++;
        $display("FAIL rstmid_reg[%0d]: got %h want %h", i, reg_rdata, mregs[i]);
      end
    end
    for (int i = 3; i >= 0; i--) send_bit(b[i]);
    recv_bit(k);
    n_cmp++;
    if (k !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ignored: ack=%b want 1 (no ACK)", k);
    end
    stop_c;
    n_cmp++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_rx: got %0d pulses want 0", got_q.size());
    end
    got_q.delete();
    start_c;
    send_byte(8'hA0, k);
    n_cmp++;
    if (k !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_rearm: ack=%b want 0", k);
    end
    stop_c;
  endtask

  task automatic test_stop_mid;
    logic [7:0] b;
    b = 8'h5A;
    write_txn(8'hA0, 8'h09, 0);
    for (int i = 7; i >= 4; i--) send_bit(b[i]);
    stop_c;
    n_cmp++;
    if (busy !== 1'b0 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL stopmid: busy=%b pulses=%0d want 0/0", busy, got_q.size());
    end
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      reg_addr = 4'(i); #1;
      n_cmp++;
      if (reg_rdata !== mregs[i]) begin
        n_fail++;
        $display("FAIL stopmid_reg[%0d]: got %h want %h", i, reg_rdata, mregs[i]);
      end
    end
    read_txn(1);
    stop_c;
    n_cmp++;
    if (rd_ack !== 1'b0 || rd_buf[0] !== mregs[mptr]) begin
      n_fail++;
      $display("FAIL stopmid_read: ack=%b data=%h want 0/%h", rd_ack, rd_buf[0], mregs[mptr]);
    end
  endtask

  initial begin
    test_reset;
    test_write_basic;
    test_wrap;
    test_read;
    test_mismatch;
    test_random;
    test_reset_mid;
    test_stop_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
